// File: rtl/axi_ad9434_pngen_if.sv
// Stream bundle between the AD9434 test-pattern generator and its consumer.
// The generator side is the master; it sources words and honours adc_ready.
interface axi_ad9434_pngen_if;
   logic [3:0]  adc_pnseq_sel;
   logic        adc_err_inject;
   logic        adc_ready;
   logic        adc_valid;
   logic [47:0] adc_data;
   logic [31:0] adc_xfer_count;

   modport master (
      input  adc_pnseq_sel,
      input  adc_err_inject,
      input  adc_ready,
      output adc_valid,
      output adc_data,
      output adc_xfer_count
   );

   modport slave (
      output adc_pnseq_sel,
      output adc_err_inject,
      output adc_ready,
      input  adc_valid,
      input  adc_data,
      input  adc_xfer_count
   );
endinterface

// File: rtl/axi_ad9434_pngen.sv
// AD9434 test-pattern source: PN9, PN23 or ramp, 4 x 12-bit samples per word,
// valid/ready handshake with single-word error injection and transfer counter.
module axi_ad9434_pngen #(
   parameter logic [8:0]  PN9_SEED  = 9'h1FF,
   parameter logic [22:0] PN23_SEED = 23'h7FFFFF
) (
   input logic                adc_clk,
   input logic                adc_rst,
   axi_ad9434_pngen_if.master pn
);

   typedef enum logic [1:0] {
      MODE_OFF,
      MODE_PN9,
      MODE_PN23,
      MODE_RAMP
   } mode_e;

   logic [3:0]  sel_q,    sel_d;
   logic        valid_q,  valid_d;
   logic [47:0] data_q,   data_d;
   logic [31:0] count_q,  count_d;
   logic        pend_q,   pend_d;
   logic        corr_q,   corr_d;
   logic [8:0]  lfsr9_q,  lfsr9_d;
   logic [22:0] lfsr23_q, lfsr23_d;
   logic [11:0] base_q,   base_d;

   mode_e       mode;
   logic        mode_chg;
   logic        xfer;
   logic        pend_load;
   logic [47:0] word;
   logic [47:0] pn9_word,  pn23_word, ramp_word;
   logic [8:0]  pn9_next;
   logic [22:0] pn23_next;

   always_comb begin
      case (sel_q)
         4'd1:    mode = MODE_PN9;
         4'd2:    mode = MODE_PN23;
         4'd3:    mode = MODE_RAMP;
         default: mode = MODE_OFF;
      endcase
   end

   assign mode_chg = (pn.adc_pnseq_sel != sel_q);
   assign xfer     = valid_q & pn.adc_ready;

   // LFSR windows hold the next unsent stream bits, window[0] first;
   // 48 steps are unrolled so a whole word is produced per cycle.
   always_comb begin : pn9_unroll
      logic [8:0] s;
      logic [5:0] idx;
      s        = lfsr9_q;
      idx      = '0;
      pn9_word = '0;
      for (int unsigned t = 0; t < 48; t++) begin
         idx           = 6'((t / 12) * 12 + 11 - (t % 12));
         pn9_word[idx] = s[0];
         s             = {s[0] ^ s[4], s[8:1]};
      end
      pn9_next = s;
   end

   always_comb begin : pn23_unroll
      logic [22:0] s;
      logic [5:0]  idx;
      s         = lfsr23_q;
      idx       = '0;
      pn23_word = '0;
      for (int unsigned t = 0; t < 48; t++) begin
         idx            = 6'((t / 12) * 12 + 11 - (t % 12));
         pn23_word[idx] = s[0];
         s              = {s[0] ^ s[5], s[22:1]};
      end
      pn23_next = s;
   end

   assign ramp_word = {base_q + 12'd3, base_q + 12'd2, base_q + 12'd1, base_q};

   always_comb begin
      sel_d     = pn.adc_pnseq_sel;
      valid_d   = valid_q;
      data_d    = data_q;
      count_d   = count_q;
      corr_d    = corr_q;
      lfsr9_d   = lfsr9_q;
      lfsr23_d  = lfsr23_q;
      base_d    = base_q;
      word      = '0;
      pend_load = pend_q & ~corr_q;
      // A corrupted word retires the request only when actually delivered;
      // a mode change discards it, so the request carries into the new mode.
      pend_d    = pn.adc_err_inject | (pend_q & ~(xfer & corr_q & ~mode_chg));

      if (mode_chg) begin
         valid_d  = 1'b0;
         data_d   = '0;
         count_d  = '0;
         corr_d   = 1'b0;
         lfsr9_d  = PN9_SEED;
         lfsr23_d = PN23_SEED;
         base_d   = '0;
      end else if (mode == MODE_OFF) begin
         valid_d = 1'b0;
         data_d  = '0;
         corr_d  = 1'b0;
      end else begin
         if (xfer) begin
            count_d = (count_q == '1) ? count_q : count_q + 32'd1;
         end
         if (!valid_q || xfer) begin
            case (mode)
               MODE_PN9: begin
                  word    = pn9_word;
                  lfsr9_d = pn9_next;
               end
               MODE_PN23: begin
                  word     = pn23_word;
                  lfsr23_d = pn23_next;
               end
               MODE_RAMP: begin
                  word   = ramp_word;
                  base_d = base_q + 12'd4;
               end
               default: word = '0;
            endcase
            data_d  = word ^ {47'd0, pend_load};
            corr_d  = pend_load;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         sel_q    <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         count_q  <= '0;
         pend_q   <= 1'b0;
         corr_q   <= 1'b0;
         lfsr9_q  <= PN9_SEED;
         lfsr23_q <= PN23_SEED;
         base_q   <= '0;
      end else begin
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         corr_q   <= corr_d;
         lfsr9_q  <= lfsr9_d;
         lfsr23_q <= lfsr23_d;
         base_q   <= base_d;
      end
   end

   assign pn.adc_valid      = valid_q;
   assign pn.adc_data       = data_q;
   assign pn.adc_xfer_count = count_q;

endmodule

// File: tb/tb_axi_ad9434_pngen.sv
// Directed bench for axi_ad9434_pngen: a bit-serial reference fills an
// expected-word queue that is drained and compared on every transfer.
module tb_axi_ad9434_pngen;

   localparam logic [8:0]  SEED9  = 9'h1FF;
   localparam logic [22:0] SEED23 = 23'h7FFFFF;

   logic clk = 1'b0;
   logic rst;

   axi_ad9434_pngen_if bus();

   axi_ad9434_pngen #(
      .PN9_SEED  (SEED9),
      .PN23_SEED (SEED23)
   ) dut (
      .adc_clk (clk),
      .adc_rst (rst),
      .pn      (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [47:0] exp_q[$];
   bit          hist[$];
   int          hk, hl, hd;
   int          rbase;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream reference: b[k] = b[k-len] ^ b[k-tap], first len bits from the seed.
   task automatic model_pn(input int len, input int tap, input logic [22:0] seed);
      logic [22:0] s;
      s = seed;
      hist.delete();
      hk = 0;
      hl = len;
      hd = tap;
      for (int i = 0; i < len; i++) begin
         hist.push_back(s[0]);
         s = s >> 1;
      end
   endtask

   task automatic next_bit(output bit b);
      if (hk >= hist.size()) hist.push_back(hist[hk - hl] ^ hist[hk - hd]);
      b = hist[hk];
      hk++;
   endtask

   task automatic push_pn(input int n, input int flip_at);
      logic [47:0] w;
      logic [11:0] samp;
      bit          nb;
      for (int i = 0; i < n; i++) begin
         w = '0;
         for (int s = 0; s < 4; s++) begin
            samp = '0;
            for (int b = 0; b < 12; b++) begin
               next_bit(nb);
               samp = {samp[10:0], nb};
            end
            w = {samp, w[47:12]};
         end
         if (i == flip_at) w = w ^ 48'd1;
         exp_q.push_back(w);
      end
   endtask

   task automatic push_ramp(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({12'(rbase + 3), 12'(rbase + 2), 12'(rbase + 1), 12'(rbase)});
         rbase = (rbase + 4) % 4096;
      end
   endtask

   task automatic drain(input string tag, input int n, input int budget, input bit rnd);
      int          got;
      bit          stalled;
      logic [47:0] held;
      got     = 0;
      stalled = 1'b0;
      held    = '0;
      for (int c = 0; c < budget && got < n; c++) begin
         if (stalled) check({tag, "_stall"}, 64'(bus.adc_data), 64'(held));
         bus.adc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.adc_valid && bus.adc_ready) begin
            check(tag, 64'(bus.adc_data), 64'(exp_q.pop_front()));
            got++;
         end
         stalled = bus.adc_valid && !bus.adc_ready;
         held    = bus.adc_data;
         tick();
      end
      check({tag, "_words"}, 64'(got), 64'(n));
   endtask

   initial begin
      rst                = 1'b1;
      bus.adc_pnseq_sel  = '0;
      bus.adc_err_inject = 1'b0;
      bus.adc_ready      = 1'b0;
      rbase              = 0;
      tick();
      tick();
      check("rst_valid", 64'(bus.adc_valid), 64'd0);
      check("rst_data",  64'(bus.adc_data),  64'd0);
      check("rst_count", 64'(bus.adc_xfer_count), 64'd0);
      rst = 1'b0;

      // PN9 start-up latency, first samples and long run
      bus.adc_pnseq_sel = 4'd1;
      bus.adc_ready     = 1'b1;
      tick();
      check("pn9_lat1", 64'(bus.adc_valid), 64'd0);
      tick();
      check("pn9_lat2", 64'(bus.adc_valid), 64'd1);
      check("pn9_s0", 64'(bus.adc_data[11:0]),  64'h0FF8);
      check("pn9_s1", 64'(bus.adc_data[23:12]), 64'h03DF);
      model_pn(9, 5, 23'(SEED9));
      push_pn(1000, -1);
      drain("pn9", 1000, 1100, 1'b0);
      check("pn9_count", 64'(bus.adc_xfer_count), 64'd1000);

      // Ramp across the 12-bit wrap
      bus.adc_pnseq_sel = 4'd3;
      tick();
      check("ramp_lat1",  64'(bus.adc_valid), 64'd0);
      check("ramp_clr",   64'(bus.adc_xfer_count), 64'd0);
      rbase = 0;
      push_ramp(1025);
      drain("ramp", 1025, 1100, 1'b0);
      check("ramp_count", 64'(bus.adc_xfer_count), 64'd1025);

      // PN23 under random backpressure
      bus.adc_ready     = 1'b0;
      bus.adc_pnseq_sel = 4'd2;
      tick();
      model_pn(23, 18, SEED23);
      push_pn(300, -1);
      drain("pn23_bp", 300, 3000, 1'b1);

      // Two inject pulses during a stall corrupt exactly the next word
      bus.adc_ready     = 1'b0;
      bus.adc_pnseq_sel = 4'd1;
      tick();
      tick();
      check("inj_valid", 64'(bus.adc_valid), 64'd1);
      model_pn(9, 5, 23'(SEED9));
      push_pn(20, 1);
      check("inj_w0_clean", 64'(bus.adc_data), 64'(exp_q[0]));
      bus.adc_err_inject = 1'b1; tick();
      bus.adc_err_inject = 1'b0; tick();
      bus.adc_err_inject = 1'b1; tick();
      bus.adc_err_inject = 1'b0; tick();
      check("inj_w0_hold", 64'(bus.adc_data), 64'(exp_q[0]));
      bus.adc_ready = 1'b1;
      check("inj_w0", 64'(bus.adc_data), 64'(exp_q.pop_front()));
      tick();
      bus.adc_ready = 1'b0;
      check("inj_w1_flip", 64'(bus.adc_data), 64'(exp_q[0]));
      tick();
      tick();
      tick();
      check("inj_w1_hold", 64'(bus.adc_data), 64'(exp_q[0]));
      drain("inj", 19, 100, 1'b0);

      // Mode change while a PN9 word is stalled discards it
      bus.adc_ready = 1'b0;
      tick();
      check("chg_stall_valid", 64'(bus.adc_valid), 64'd1);
      bus.adc_pnseq_sel = 4'd3;
      tick();
      check("chg_valid", 64'(bus.adc_valid), 64'd0);
      check("chg_count", 64'(bus.adc_xfer_count), 64'd0);
      bus.adc_ready = 1'b1;
      rbase = 0;
      push_ramp(10);
      drain("chg_ramp", 10, 50, 1'b0);

      // Upper select codes are off
      bus.adc_pnseq_sel = 4'd9;
      tick();
      tick();
      check("off_valid", 64'(bus.adc_valid), 64'd0);
      check("off_data",  64'(bus.adc_data),  64'd0);
      check("off_count", 64'(bus.adc_xfer_count), 64'd0);

      // Inject on the mode-change edge hits the first word of the new mode
      bus.adc_pnseq_sel  = 4'd1;
      bus.adc_err_inject = 1'b1;
      tick();
      bus.adc_err_inject = 1'b0;
      model_pn(9, 5, 23'(SEED9));
      push_pn(5, 0);
      drain("inj_chg", 5, 30, 1'b0);

      // Reset in the middle of a PN23 stream, select held
      bus.adc_pnseq_sel = 4'd2;
      tick();
      model_pn(23, 18, SEED23);
      push_pn(5, -1);
      drain("pn23_pre", 5, 30, 1'b0);
      rst                = 1'b1;
      bus.adc_err_inject = 1'b1;
      tick();
      check("mrst_valid", 64'(bus.adc_valid), 64'd0);
      check("mrst_data",  64'(bus.adc_data),  64'd0);
      check("mrst_count", 64'(bus.adc_xfer_count), 64'd0);
      rst                = 1'b0;
      bus.adc_err_inject = 1'b0;
      tick();
      check("mrst_lat1", 64'(bus.adc_valid), 64'd0);
      tick();
      check("mrst_lat2", 64'(bus.adc_valid), 64'd1);
      model_pn(23, 18, SEED23);
      push_pn(10, -1);
      drain("pn23_post", 10, 40, 1'b0);
      check("mrst_count_end", 64'(bus.adc_xfer_count), 64'd10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
